// File: rtl/fadd_norm_round.sv
// fadd_norm_round: final stage of the pipelined single-precision FP adder.
// Takes the calc->norm pipeline fields, normalizes (stage A), then rounds,
// handles overflow/specials and packs the IEEE-754 word (stage B).
// A valid/ready handshake lets downstream backpressure stall the adder.
// Bubbles collapse, so a stalled output still lets stage A fill.
//
// Ports:
//   clk, clrn           clock (rising edge), async active-low reset
//   in_valid/in_ready   input handshake; in_ready is combinational from out_ready
//   n_rm                rounding mode: 00 RNE, 01 -inf, 10 +inf, 11 toward zero
//   n_is_nan, n_is_inf  special-result flags
//   n_inf_nan_frac      fraction used for NaN results
//   n_sign, n_exp       result sign, pre-normalization exponent
//   n_frac              pre-normalization fraction:
//                       [27] carry, [26] hidden, [25:3] mantissa, [2:0] G/R/S
//   out_valid/out_ready output handshake; s holds while out_valid & !out_ready
//   s                   packed result {sign, exp, frac}
// Optional build macro FADD_NORM_FLAGS_EN adds:
//   flags     {invalid, overflow, underflow, inexact} for the current s
//   flags_acc sticky OR of flags over every output handshake
//   flags_clr synchronous clear of flags_acc
module fadd_norm_round #(
  parameter int FRAC_W = 28,
  parameter int EXP_W  = 8
) (
  input  logic                      clk,
  input  logic                      clrn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                n_rm,
  input  logic                      n_is_nan,
  input  logic                      n_is_inf,
  input  logic [FRAC_W-6:0]         n_inf_nan_frac,
  input  logic                      n_sign,
  input  logic [EXP_W-1:0]          n_exp,
  input  logic [FRAC_W-1:0]         n_frac,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W-5:0]   s
`ifdef FADD_NORM_FLAGS_EN
  ,
  output logic [3:0]                flags,
  output logic [3:0]                flags_acc,
  input  logic                      flags_clr
`endif
);
  localparam int MW = FRAC_W - 5;      // stored mantissa bits
  localparam int NF = FRAC_W - 1;      // normalized fraction: carry bit is always 0
  localparam int EW = EXP_W + 1;       // headroom so exponent overflow is visible
  localparam int ZW = $clog2(FRAC_W);
  localparam int SW = 1 + EXP_W + MW;

  // handshake
  logic a_valid_q, a_valid_d, out_valid_q, out_valid_d;
  logic a_adv, b_adv;

  assign b_adv    = !out_valid_q | out_ready;
  assign a_adv    = !a_valid_q | b_adv;
  assign in_ready = a_adv;

  // ---------------- stage A: normalize ----------------
  logic [ZW-1:0]    z;
  logic [EXP_W-1:0] dshift;
  logic [NF-1:0]    norm_frac;
  logic [EW-1:0]    norm_exp;

  always_comb begin
    // leading zeros counted from the hidden-bit position; 27 when all zero
    z = ZW'(FRAC_W - 1);
    for (int i = 0; i < FRAC_W - 1; i++)
      if (n_frac[i]) z = ZW'(FRAC_W - 2 - i);
    dshift    = (n_exp == '0) ? '0 : n_exp - EXP_W'(1);
    norm_frac = '0;
    norm_exp  = '0;
    if (n_frac[FRAC_W-1]) begin
      // carry out of the add: shift right, fold the dropped bit into sticky
      norm_frac = {n_frac[FRAC_W-1:2], n_frac[1] | n_frac[0]};
      norm_exp  = {1'b0, n_exp} + EW'(1);
    end else if (n_frac[FRAC_W-2:0] == '0) begin
      norm_frac = '0;
      norm_exp  = '0;
    end else if ({1'b0, n_exp} > EW'(z)) begin
      norm_frac = n_frac[NF-1:0] << z;
      norm_exp  = {1'b0, n_exp} - EW'(z);
    end else begin
      // exponent runs out before the hidden bit is reached: denormal result
      norm_frac = n_frac[NF-1:0] << dshift;
      norm_exp  = '0;
    end
  end

  logic [1:0]    a_rm_q, a_rm_d;
  logic          a_nan_q, a_nan_d, a_inf_q, a_inf_d, a_sign_q, a_sign_d;
  logic [MW-1:0] a_inf_nan_frac_q, a_inf_nan_frac_d;
  logic [EW-1:0] a_exp_q, a_exp_d;
  logic [NF-1:0] a_frac_q, a_frac_d;

  always_comb begin
    a_valid_d        = a_valid_q;
    a_rm_d           = a_rm_q;
    a_nan_d          = a_nan_q;
    a_inf_d          = a_inf_q;
    a_sign_d         = a_sign_q;
    a_inf_nan_frac_d = a_inf_nan_frac_q;
    a_exp_d          = a_exp_q;
    a_frac_d         = a_frac_q;
    if (a_adv) a_valid_d = in_valid;
    if (a_adv && in_valid) begin
      a_rm_d           = n_rm;
      a_nan_d          = n_is_nan;
      a_inf_d          = n_is_inf;
      a_sign_d         = n_sign;
      a_inf_nan_frac_d = n_inf_nan_frac;
      a_exp_d          = norm_exp;
      a_frac_d         = norm_frac;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      a_valid_q        <= 1'b0;
      a_rm_q           <= '0;
      a_nan_q          <= 1'b0;
      a_inf_q          <= 1'b0;
      a_sign_q         <= 1'b0;
      a_inf_nan_frac_q <= '0;
      a_exp_q          <= '0;
      a_frac_q         <= '0;
    end else begin
      a_valid_q        <= a_valid_d;
      a_rm_q           <= a_rm_d;
      a_nan_q          <= a_nan_d;
      a_inf_q          <= a_inf_d;
      a_sign_q         <= a_sign_d;
      a_inf_nan_frac_q <= a_inf_nan_frac_d;
      a_exp_q          <= a_exp_d;
      a_frac_q         <= a_frac_d;
    end
  end

  // ---------------- stage B: round, overflow, pack ----------------
  logic [2:0]    grs;
  logic          inc, ovf, to_inf;
  logic [MW+1:0] m;
  logic [EW-1:0] exp_r;
  logic [MW-1:0] mant;
  logic [SW-1:0] res, s_q, s_d;

  always_comb begin
    grs = a_frac_q[2:0];
    case (a_rm_q)
      2'b00:   inc = grs[2] & (grs[1] | grs[0] | a_frac_q[3]);
      2'b01:   inc = a_sign_q & (|grs);
      2'b10:   inc = !a_sign_q & (|grs);
      default: inc = 1'b0;
    endcase
    m     = {1'b0, a_frac_q[NF-1:3]} + (MW+2)'(inc);
    exp_r = a_exp_q;
    mant  = m[MW-1:0];
    if (m[MW+1]) begin
      mant  = m[MW:1];
      exp_r = a_exp_q + EW'(1);
    end else if (a_exp_q == '0 && m[MW]) begin
      // denormal rounded up into the normal range
      exp_r = EW'(1);
    end
    ovf    = exp_r >= EW'((1 << EXP_W) - 1);
    // overflow goes to infinity for RNE or when rounding toward that infinity
    to_inf = (a_rm_q == 2'b00) | (a_rm_q == 2'b01 & a_sign_q) | (a_rm_q == 2'b10 & !a_sign_q);
    res    = {a_sign_q, exp_r[EXP_W-1:0], mant};
    if (a_nan_q)
      res = {a_sign_q, {EXP_W{1'b1}}, a_inf_nan_frac_q};
    else if (a_inf_q)
      res = {a_sign_q, {EXP_W{1'b1}}, {MW{1'b0}}};
    else if (ovf)
      res = to_inf ? {a_sign_q, {EXP_W{1'b1}}, {MW{1'b0}}}
                   : {a_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MW{1'b1}}};
    out_valid_d = b_adv ? a_valid_q : out_valid_q;
    s_d         = (b_adv && a_valid_q) ? res : s_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;

`ifdef FADD_NORM_FLAGS_EN
  logic [3:0] flg, flags_q, flags_d, flags_acc_q, flags_acc_d;
  logic       hs;

  always_comb begin
    flg = '0;
    if (a_nan_q) begin
      flg = 4'b1000;
    end else if (!a_inf_q) begin
      flg[2] = ovf;
      flg[0] = (|grs) | ovf;
      flg[1] = !ovf & (exp_r == '0) & (|grs);
    end
    flags_d = (b_adv && a_valid_q) ? flg : flags_q;
    hs      = out_valid_q & out_ready;
    // a clear that lands on a handshake still records that result's flags
    flags_acc_d = flags_clr ? (hs ? flags_q : '0) : (flags_acc_q | (hs ? flags_q : '0));
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flags_q     <= '0;
      flags_acc_q <= '0;
    end else begin
      flags_q     <= flags_d;
      flags_acc_q <= flags_acc_d;
    end
  end

  assign flags     = flags_q;
  assign flags_acc = flags_acc_q;
`endif
endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: directed vector table, backpressure and reset
// sequences, and a randomized run scored against a value-level model.
module tb_fadd_norm_round;
  logic        clk = 1'b0, clrn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  n_rm = '0;
  logic        n_is_nan = 1'b0, n_is_inf = 1'b0, n_sign = 1'b0;
  logic [22:0] n_inf_nan_frac = '0;
  logic [7:0]  n_exp = '0;
  logic [27:0] n_frac = '0;
  logic        out_valid, out_ready;
  logic [31:0] s;
  logic        rnd_en = 1'b0, rnd_rdy = 1'b1, or_man = 1'b1;
`ifdef FADD_NORM_FLAGS_EN
  logic [3:0]  flags, flags_acc, acc_m = '0;
  logic        flags_clr = 1'b0;
`endif

  assign out_ready = rnd_en ? rnd_rdy : or_man;
  always #5 clk = ~clk;

  fadd_norm_round dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .n_rm(n_rm), .n_is_nan(n_is_nan), .n_is_inf(n_is_inf),
    .n_inf_nan_frac(n_inf_nan_frac), .n_sign(n_sign), .n_exp(n_exp),
    .n_frac(n_frac), .out_valid(out_valid), .out_ready(out_ready), .s(s)
`ifdef FADD_NORM_FLAGS_EN
    , .flags(flags), .flags_acc(flags_acc), .flags_clr(flags_clr)
`endif
  );

  typedef struct packed {
    logic [1:0]  rm;
    logic        nan;
    logic        inf;
    logic [22:0] inff;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] frac;
    logic [31:0] exp_s;
  } vec_t;

  int          n_checks = 0, n_fail = 0, n_pop = 0;
  logic        sb_en = 1'b0;
  logic [35:0] q[$];
  logic [35:0] sb_exp;
  vec_t        cur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, req);
    end
  endtask

  // Reference: IEEE value rules with plain integer arithmetic.
  // Returns {flags[3:0], s[31:0]}.
  function automatic logic [35:0] model(input vec_t v);
    longint     f, m;
    int         e, z;
    logic [2:0] grs;
    logic       inc, up, to_inf;
    f = longint'(v.frac);
    e = int'(v.exp);
    if (v.nan) return {4'b1000, v.sign, 8'hFF, v.inff};
    if (v.inf) return {4'b0000, v.sign, 8'hFF, 23'h0};
    if (f >= (longint'(1) << 27)) begin
      f = (f >> 1) | (f & 1);
      e = e + 1;
    end else if (f == 0) begin
      e = 0;
    end else begin
      z = 0;
      while (f < (longint'(1) << (26 - z))) z++;
      if (e > z) begin
        f = f << z;
        e = e - z;
      end else begin
        f = f << ((e == 0) ? 0 : e - 1);
        e = 0;
      end
    end
    grs = f[2:0];
    up  = (grs != 3'b000);
    case (v.rm)
      2'd0:    inc = grs[2] & (grs[1] | grs[0] | f[3]);
      2'd1:    inc = v.sign & up;
      2'd2:    inc = !v.sign & up;
      default: inc = 1'b0;
    endcase
    m = (f >> 3) + longint'(inc);
    if (m >= (longint'(1) << 24)) begin
      m = m >> 1;
      e = e + 1;
    end else if (e == 0 && m >= (longint'(1) << 23)) begin
      e = 1;
    end
    if (e >= 255) begin
      to_inf = (v.rm == 2'd0) || (v.rm == 2'd1 && v.sign) || (v.rm == 2'd2 && !v.sign);
      return to_inf ? {4'b0101, v.sign, 8'hFF, 23'h0} : {4'b0101, v.sign, 8'hFE, 23'h7FFFFF};
    end
    return {2'b00, (e == 0) && up, up, v.sign, e[7:0], m[22:0]};
  endfunction

  function automatic vec_t mk(input logic [1:0] rm, input logic sg, input logic [7:0] e,
                              input logic [27:0] f, input logic [31:0] xs);
    vec_t v;
    v = '0;
    v.rm = rm; v.sign = sg; v.exp = e; v.frac = f; v.exp_s = xs;
    return v;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    int   r;
    v      = '0;
    r      = $urandom_range(0, 31);
    v.rm   = 2'($urandom_range(0, 3));
    v.nan  = (r == 0);
    v.inf  = (r == 1);
    v.inff = 23'($urandom);
    v.sign = 1'($urandom);
    v.exp  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
    v.frac = 28'($urandom) >> $urandom_range(0, 28);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cur            = v;
    n_rm           = v.rm;
    n_is_nan       = v.nan;
    n_is_inf       = v.inf;
    n_inf_nan_frac = v.inff;
    n_sign         = v.sign;
    n_exp          = v.exp;
    n_frac         = v.frac;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard: inputs accepted and outputs consumed on the coming edge
  always @(negedge clk) begin
    if (sb_en && clrn) begin
      if (in_valid && in_ready) q.push_back(model(cur));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%08h, want no output", s);
        end else begin
          sb_exp = q.pop_front();
          n_pop++;
          chk("sb_s", s, sb_exp[31:0]);
`ifdef FADD_NORM_FLAGS_EN
          chk("sb_flags", 32'(flags), 32'(sb_exp[35:32]));
          acc_m = acc_m | sb_exp[35:32];
`endif
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin
    vec_t        tbl[16];
    vec_t        bp[4];
    logic [31:0] held;
    int          pop0, n;

    tbl[0]  = mk(2'd0, 1'b0, 8'd127, 28'h8000000, 32'h40000000);
    tbl[1]  = mk(2'd0, 1'b0, 8'd127, 28'h0000008, 32'h34000000);
    tbl[2]  = mk(2'd0, 1'b0, 8'd127, 28'h4000004, 32'h3F800000);
    tbl[3]  = mk(2'd2, 1'b0, 8'd127, 28'h4000004, 32'h3F800001);
    tbl[4]  = mk(2'd1, 1'b1, 8'd127, 28'h4000004, 32'hBF800001);
    tbl[5]  = mk(2'd3, 1'b0, 8'd127, 28'h4000004, 32'h3F800000);
    tbl[6]  = mk(2'd0, 1'b0, 8'd254, 28'h8000000, 32'h7F800000);
    tbl[7]  = mk(2'd3, 1'b0, 8'd254, 28'h8000000, 32'h7F7FFFFF);
    tbl[8]  = mk(2'd0, 1'b0, 8'd0,   28'h0,       32'h7FC00000);
    tbl[8].nan  = 1'b1;
    tbl[8].inff = 23'h400000;
    tbl[9]  = mk(2'd0, 1'b1, 8'd10,  28'h123,     32'hFF800000);
    tbl[9].inf  = 1'b1;
    tbl[10] = mk(2'd0, 1'b1, 8'd50,  28'h0,       32'h80000000);
    tbl[11] = mk(2'd0, 1'b0, 8'd1,   28'h0400000, 32'h00080000);
    tbl[12] = mk(2'd0, 1'b0, 8'd0,   28'h3FFFFFC, 32'h00800000);
    tbl[13] = mk(2'd0, 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000);
    tbl[14] = mk(2'd2, 1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000);
    tbl[15] = mk(2'd2, 1'b0, 8'd127, 28'h8000001, 32'h40000001);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", s, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    clrn = 1'b1;

    // directed table: one vector at a time, two-cycle latency
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_lat1", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_s", i), s, tbl[i].exp_s);
`ifdef FADD_NORM_FLAGS_EN
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(model(tbl[i]) >> 32));
`endif
    end

    // backpressure: out_ready low for 3 cycles while streaming 4 inputs
    @(posedge clk); #1;
`ifdef FADD_NORM_FLAGS_EN
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    acc_m = '0;
    @(negedge clk);
    chk("acc_clr", 32'(flags_acc), 32'd0);
    @(posedge clk); #1;
`endif
    bp[0] = tbl[0]; bp[1] = tbl[1]; bp[2] = tbl[3]; bp[3] = tbl[12];
    sb_en  = 1'b1;
    pop0   = n_pop;
    or_man = 1'b0;
    drive(bp[0]);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(bp[1]);
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(bp[2]);
    @(negedge clk);
    chk("bp_ready_drop", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_s0", s, bp[0].exp_s);
    held = s;
    @(posedge clk); #1;
    or_man = 1'b1;
    @(negedge clk);
    chk("bp_hold", s, held);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    drive(bp[3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_count", 32'(n_pop - pop0), 32'd4);

    // randomized stream with random backpressure
    rnd_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_vec());
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_en = 1'b0;
    or_man = 1'b1;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
`ifdef FADD_NORM_FLAGS_EN
    @(negedge clk);
    chk("flags_acc", 32'(flags_acc), 32'(acc_m));
`endif

    // NaN result, then asynchronous reset while out_valid is high
    sb_en = 1'b0;
    @(posedge clk); #1;
    drive(tbl[8]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("nan_valid", 32'(out_valid), 32'd1);
    chk("nan_s", s, 32'h7FC00000);
    clrn = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_s", s, 32'h0);
    q.delete();
    @(posedge clk); #1;
    clrn = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
